// File: rtl/mem_pkg.sv
// Shared constants and types for the memory-access pipeline stage.
package mem_pkg;

  // Major opcodes the stage needs to distinguish
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  // Load size/sign selectors
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store size selectors
  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  typedef enum logic {IDLE, ACCESS} state_t;

  // A halfword must sit on an even byte, a word on a multiple of four
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    if (funct3[1:0] == 2'b01) mis = lane[0];
    else if (funct3[1:0] == 2'b10) mis = (lane != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit data bus and sub-word accesses:
// byte enables and replicated store data going out, extended load data coming back.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] B,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Size-driven enables and lane replication; misaligned halfwords fall onto lane addr[1]
  always_comb begin
    be    = 4'b1111;
    wdata = B;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr;
        wdata = {4{B[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {addr[1], 1'b0};
        wdata = {2{B[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = B;
      end
    endcase
  end

  // Pick the addressed byte/halfword out of the returned word and extend it
  always_comb begin
    byte_v    = rdata[7:0];
    half_v    = addr[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (addr)
      2'b00:   byte_v = rdata[7:0];
      2'b01:   byte_v = rdata[15:8];
      2'b10:   byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    case (funct3)
      LB:      load_data = {{24{byte_v[7]}}, byte_v};
      LH:      load_data = {{16{half_v[15]}}, half_v};
      LBU:     load_data = {24'h0, byte_v};
      LHU:     load_data = {16'h0, half_v};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage between execute and writeback.
// Loads/stores run a req/ack transaction on the data port; everything else
// passes straight into the output register. Optional feature macro:
// MEM_MISALIGN_TRAP_EN - misaligned halfword/word accesses skip memory and
// return the faulting address with the misalign flag set.
module mem_access
  import mem_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_ALIGN = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] IR,
  input  logic [XLEN-1:0] ALU,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      AA,
  input  logic            v_in,
  output logic            r_out,
  output logic            v_out,
  input  logic            r_in,
  output logic            stall_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic [XLEN-1:0] IR_out,
  output logic [XLEN-1:0] WB_out,
  output logic [XLEN-1:0] FM,
  output logic [4:0]      AM,
  output logic            misalign
);

  state_t state_q, state_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_mem;
  logic            accept;
  logic            trap;

  logic [XLEN-1:0] pend_ir;
  logic [4:0]      pend_aa;
  logic [1:0]      pend_lane;
  logic            pend_is_load;

  logic            v_out_q;
  logic [XLEN-1:0] ir_out_q;
  logic [XLEN-1:0] wb_out_q;
  logic [4:0]      am_q;

  logic [2:0]      la_funct3;
  logic [1:0]      la_addr;
  logic [3:0]      la_be;
  logic [31:0]     la_wdata;
  logic [31:0]     la_load;

  logic [XLEN-1:0] pass_wb;
  logic [4:0]      pass_am;

  assign opcode       = IR[6:0];
  assign funct3       = IR[14:12];
  assign is_mem       = (opcode == LOAD) || (opcode == STORE);
  assign r_out        = (state_q == IDLE) && (!v_out_q || r_in);
  assign stall_out    = !r_out;
  assign accept       = v_in && r_out;
  assign pend_is_load = (pend_ir[6:0] == LOAD);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_mem && is_misaligned(funct3, ALU[1:0]);
`else
  assign trap = 1'b0;
`endif

  // While a transaction is open the aligner must look at the captured access, not execute's
  assign la_funct3 = (state_q == ACCESS) ? pend_ir[14:12] : funct3;
  assign la_addr   = (state_q == ACCESS) ? pend_lane : ALU[1:0];

  mem_lane_align u_lane_align (
    .funct3    (la_funct3),
    .addr      (la_addr),
    .B         (B),
    .rdata     (dmem_rdata),
    .be        (la_be),
    .wdata     (la_wdata),
    .load_data (la_load)
  );

  // Result and forwarding address for anything that does not wait on memory
  always_comb begin
    pass_wb = ALU;
    pass_am = AA;
    if ((opcode == JAL) || (opcode == JALR)) pass_wb = PC + XLEN'(4);
    if ((opcode == BRANCH) || (opcode == STORE) || (opcode == LOAD)) pass_am = '0;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Enter ACCESS on an accepted aligned load/store, leave on the ack strobe
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mem && !trap) state_d = ACCESS;
      ACCESS:  if (dmem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output register, memory request register and captured access details
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_out_q    <= 1'b0;
      ir_out_q   <= '0;
      wb_out_q   <= '0;
      am_q       <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      pend_ir    <= '0;
      pend_aa    <= '0;
      pend_lane  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mem && !trap) begin
              v_out_q    <= 1'b0;
              dmem_req   <= 1'b1;
              dmem_we    <= (opcode == STORE);
              dmem_be    <= la_be;
              dmem_addr  <= {ALU[XLEN-1:ADDR_ALIGN], {ADDR_ALIGN{1'b0}}};
              dmem_wdata <= la_wdata;
              pend_ir    <= IR;
              pend_aa    <= AA;
              pend_lane  <= ALU[1:0];
            end else begin
              v_out_q  <= 1'b1;
              ir_out_q <= IR;
              wb_out_q <= pass_wb;
              am_q     <= pass_am;
            end
          end else if (v_out_q && r_in) begin
            v_out_q <= 1'b0;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= '0;
            v_out_q  <= 1'b1;
            ir_out_q <= pend_ir;
            wb_out_q <= pend_is_load ? la_load : '0;
            am_q     <= pend_is_load ? pend_aa : '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;

  // Remember whether the current output is a trapped access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else if ((state_q == IDLE) && accept) misalign_q <= trap;
    else if ((state_q == ACCESS) && dmem_ack) misalign_q <= 1'b0;
  end

  assign misalign = v_out_q && misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign v_out  = v_out_q;
  assign IR_out = ir_out_q;
  assign WB_out = wb_out_q;
  assign FM     = wb_out_q;
  assign AM     = v_out_q ? am_q : '0;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: a byte-addressed memory model predicts each
// result at issue time; a monitor compares outputs, a responder checks requests.
module tb_mem_access;

  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_OPIMM  = 7'b0010011;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [31:0] MEM_BASE = 32'h1000;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] wb;
    logic [4:0]  am;
    logic        mis;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IR, ALU, PC, B;
  logic [4:0]  AA;
  logic        v_in, r_out, v_out, r_in, stall_out;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] IR_out, WB_out, FM;
  logic [4:0]  AM;
  logic        misalign;

  exp_t exp_q[$];
  req_t req_q[$];
  logic [7:0]  model_mem [logic [31:0]];
  logic [31:0] dut_word  [logic [31:0]];

  int n_checks = 0;
  int n_pass   = 0;
  bit ack_block = 0;
  bit rin_force = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst_n(rst_n), .IR(IR), .ALU(ALU), .PC(PC), .B(B), .AA(AA),
    .v_in(v_in), .r_out(r_out), .v_out(v_out), .r_in(r_in), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .IR_out(IR_out), .WB_out(WB_out), .FM(FM), .AM(AM), .misalign(misalign)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  function automatic logic [7:0] rdByte(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] rdWord(input logic [31:0] a);
    return dut_word.exists(a) ? dut_word[a] : 32'h0;
  endfunction

  // Reference behaviour: sizes, lanes and extension derived from byte addresses
  task automatic modelIssue(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] pc,
                            input logic [31:0] b, input logic [4:0] aa);
    exp_t e;
    req_t r;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] size, start, v;
    op = ir[6:0];
    f3 = ir[14:12];
    e.ir = ir; e.wb = alu; e.am = aa; e.mis = 1'b0;
    if (op == T_LOAD || op == T_STORE) begin
      size  = (f3[1:0] == 2'b00) ? 32'd1 : (f3[1:0] == 2'b01) ? 32'd2 : 32'd4;
      start = alu & ~(size - 32'd1);
`ifdef MEM_MISALIGN_TRAP_EN
      if ((alu & (size - 32'd1)) != 0) begin
        e.am = '0; e.mis = 1'b1;
        exp_q.push_back(e);
        return;
      end
`endif
      r.addr = alu & ~32'h3;
      r.be = '0;
      for (int k = 0; k < int'(size); k++) r.be[(start[1:0] + k) % 4] = 1'b1;
      if (op == T_LOAD) begin
        r.we = 1'b0; r.wdata = '0;
        v = '0;
        for (int k = 0; k < int'(size); k++) v |= 32'(rdByte(start + 32'(k))) << (8 * k);
        if (!f3[2] && size == 1 && v[7])  v |= 32'hFFFF_FF00;
        if (!f3[2] && size == 2 && v[15]) v |= 32'hFFFF_0000;
        e.wb = v;
      end else begin
        r.we = 1'b1;
        r.wdata = (size == 1) ? {4{b[7:0]}} : (size == 2) ? {2{b[15:0]}} : b;
        for (int k = 0; k < int'(size); k++) model_mem[start + 32'(k)] = b[8*k +: 8];
        e.wb = '0; e.am = '0;
      end
      req_q.push_back(r);
    end else if (op == T_JAL || op == T_JALR) begin
      e.wb = pc + 32'd4;
    end else if (op == T_BRANCH) begin
      e.am = '0;
    end
    exp_q.push_back(e);
  endtask

  // Present one instruction until the stage takes it
  task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] pc,
                               input logic [31:0] b, input logic [4:0] aa);
    bit done;
    done = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      r_in = rin_force ? 1'b1 : ($urandom_range(0, 3) != 0);
      v_in = 1'b1; IR = ir; ALU = alu; PC = pc; B = b; AA = aa;
      #1;
      if (r_out) begin
        modelIssue(ir, alu, pc, b, aa);
        done = 1;
      end
    end
    checkOutput("accept within bound", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) begin
      @(negedge clk);
      v_in = 1'b0; r_in = 1'b1;
    end
    @(negedge clk);
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] mkIr(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    logic [31:0] ir;
    ir = $urandom;
    ir[6:0] = op; ir[14:12] = f3; ir[11:7] = rd;
    return ir;
  endfunction

  // Monitor: compare presented outputs against the head of the scoreboard
  initial begin : monitor
    exp_t e;
    bit held;
    held = 0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) held = 0;
      else begin
        if (held) checkOutput("v_out held under backpressure", 32'(v_out), 32'd1);
        if (!v_out) begin
          checkOutput("AM zero while invalid", 32'(AM), 32'd0);
          held = 0;
        end else if (exp_q.size() == 0) begin
          checkOutput("unexpected v_out", 32'(v_out), 32'd0);
          held = 0;
        end else begin
          e = exp_q[0];
          checkOutput("IR_out", IR_out, e.ir);
          checkOutput("WB_out", WB_out, e.wb);
          checkOutput("FM", FM, e.wb);
          checkOutput("AM", 32'(AM), 32'(e.am));
          checkOutput("misalign", 32'(misalign), 32'(e.mis));
          if (r_in) begin
            void'(exp_q.pop_front());
            held = 0;
          end else begin
            checkOutput("r_out under backpressure", 32'(r_out), 32'd0);
            checkOutput("stall_out under backpressure", 32'(stall_out), 32'd1);
            held = 1;
          end
        end
      end
    end
  end

  // Memory responder: check each request, ack after a random delay
  initial begin : responder
    req_t r;
    int lat;
    logic [31:0] wa, w;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk); #1;
      if (rst_n && dmem_req && !ack_block) begin
        if (req_q.size() == 0) begin
          checkOutput("unexpected dmem_req", 32'(dmem_req), 32'd0);
        end else begin
          r = req_q.pop_front();
          checkOutput("dmem_addr", dmem_addr, r.addr);
          checkOutput("dmem_be", 32'(dmem_be), 32'(r.be));
          checkOutput("dmem_we", 32'(dmem_we), 32'(r.we));
          if (r.we) checkOutput("dmem_wdata", dmem_wdata, r.wdata);
          checkOutput("stall_out during access", 32'(stall_out), 32'd1);
          lat = $urandom_range(0, 3);
          for (int i = 0; i < lat; i++) begin
            @(negedge clk); #1;
            checkOutput("dmem_req held", 32'(dmem_req), 32'd1);
            checkOutput("dmem_addr held", dmem_addr, r.addr);
            checkOutput("dmem_be held", 32'(dmem_be), 32'(r.be));
            checkOutput("stall_out during access", 32'(stall_out), 32'd1);
          end
        end
        wa = dmem_addr;
        w = rdWord(wa);
        if (dmem_we) begin
          for (int k = 0; k < 4; k++) if (dmem_be[k]) w[8*k +: 8] = dmem_wdata[8*k +: 8];
          dut_word[wa] = w;
          dmem_rdata = $urandom;
        end else begin
          dmem_rdata = w;
        end
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [31:0] val, ir, alu;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    rst_n = 1'b0; v_in = 1'b0; r_in = 1'b1;
    IR = '0; ALU = '0; PC = '0; B = '0; AA = '0;
    for (int w = 0; w < 16; w++) begin
      val = $urandom;
      dut_word[MEM_BASE + 32'(4 * w)] = val;
      for (int k = 0; k < 4; k++) model_mem[MEM_BASE + 32'(4 * w + k)] = val[8*k +: 8];
    end
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset v_out", 32'(v_out), 32'd0);
    checkOutput("reset dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("reset dmem_we", 32'(dmem_we), 32'd0);
    checkOutput("reset dmem_be", 32'(dmem_be), 32'd0);
    checkOutput("reset dmem_addr", dmem_addr, 32'd0);
    checkOutput("reset dmem_wdata", dmem_wdata, 32'd0);
    checkOutput("reset IR_out", IR_out, 32'd0);
    checkOutput("reset WB_out", WB_out, 32'd0);
    checkOutput("reset AM", 32'(AM), 32'd0);
    checkOutput("reset misalign", 32'(misalign), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("r_out after reset", 32'(r_out), 32'd1);

    $display("[TB] directed cases");
    rin_force = 1;
    applyStimulus(mkIr(T_OPIMM, 3'b000, 5'd5), 32'h1234, 32'h80, 32'h0, 5'd5);
    applyStimulus(mkIr(T_JAL, 3'b000, 5'd1), 32'h5555, 32'h100, 32'h0, 5'd1);
    dut_word[MEM_BASE] = 32'h8000_0000;
    for (int k = 0; k < 4; k++) model_mem[MEM_BASE + 32'(k)] = (k == 3) ? 8'h80 : 8'h00;
    applyStimulus(mkIr(T_LOAD, 3'b000, 5'd3), 32'h1003, 32'h104, 32'h0, 5'd3);
    applyStimulus(mkIr(T_STORE, 3'b001, 5'd0), 32'h2002, 32'h108, 32'hABCD_1234, 5'd7);
    applyStimulus(mkIr(T_LOAD, 3'b001, 5'd4), 32'h2002, 32'h10C, 32'h0, 5'd4);
    drain();
    applyStimulus(mkIr(T_OPIMM, 3'b000, 5'd9), 32'hCAFE, 32'h110, 32'h0, 5'd9);
    repeat (2) begin
      @(negedge clk);
      v_in = 1'b0; r_in = 1'b0;
    end
    applyStimulus(mkIr(T_OPIMM, 3'b000, 5'd10), 32'hBEEF, 32'h114, 32'h0, 5'd10);
    applyStimulus(mkIr(T_LOAD, 3'b010, 5'd11), 32'h1001, 32'h118, 32'h0, 5'd11);
    drain();

    $display("[TB] randomized traffic");
    rin_force = 0;
    for (int n = 0; n < 300; n++) begin
      rd = 5'($urandom_range(0, 31));
      f3 = 3'($urandom_range(0, 7));
      alu = $urandom;
      case ($urandom_range(0, 7))
        0:       op = T_OPIMM;
        1:       op = T_LUI;
        2:       op = T_JAL;
        3:       op = T_JALR;
        4:       op = T_BRANCH;
        5, 6:    op = T_LOAD;
        default: op = T_STORE;
      endcase
      if (op == T_LOAD) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
        endcase
      end else if (op == T_STORE) begin
        f3 = 3'($urandom_range(0, 2));
      end
      if (op == T_LOAD || op == T_STORE) alu = MEM_BASE + 32'($urandom_range(0, 63));
      ir = mkIr(op, f3, rd);
      applyStimulus(ir, alu, $urandom & ~32'h3, $urandom, rd);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        v_in = 1'b0; r_in = ($urandom_range(0, 1) != 0);
      end
    end
    drain();

    $display("[TB] reset during access");
    rin_force = 1;
    ack_block = 1;
    applyStimulus(mkIr(T_LOAD, 3'b010, 5'd7), 32'h1008, 32'h200, 32'h0, 5'd7);
    for (int t = 0; t < 10 && !dmem_req; t++) @(negedge clk);
    #1;
    checkOutput("dmem_req before reset", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("dmem_req dropped by reset", 32'(dmem_req), 32'd0);
    checkOutput("v_out dropped by reset", 32'(v_out), 32'd0);
    exp_q.delete();
    req_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    v_in = 1'b0;
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    checkOutput("late ack ignored v_out", 32'(v_out), 32'd0);
    checkOutput("late ack ignored dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("late ack ignored r_out", 32'(r_out), 32'd1);
    checkOutput("late ack ignored WB_out", WB_out, 32'd0);
    ack_block = 0;
    applyStimulus(mkIr(T_OPIMM, 3'b000, 5'd12), 32'h4242, 32'h204, 32'h0, 5'd12);
    drain();
    checkOutput("request queue drained", 32'(req_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
